// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the EX-stage hazard/forwarding controller.
//   REG_ADDR_W / SEL_W : register index and forwarding select widths
//   FWD_*              : operand mux select encodings
//   shadow_t           : one shadow pipeline entry (EX, MEM or WB)
//   state_e            : controller state
//   reg_match/fwd_sel  : producer match and select resolution helpers
package hazard_fwd_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int SEL_W      = 2;

    localparam logic [SEL_W-1:0] FWD_REG = 2'b00;
    localparam logic [SEL_W-1:0] FWD_WB  = 2'b01;
    localparam logic [SEL_W-1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } shadow_t;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2
    } state_e;

    // x0 is never a producer: its writes are discarded.
    function automatic logic reg_match(input logic [REG_ADDR_W-1:0] src, input shadow_t st);
        return st.valid && st.reg_write && (st.rd != '0) && (st.rd == src);
    endfunction

    // EX beats MEM (younger value). A load in EX cannot forward; that case is
    // covered by the load-use stall. WB needs nothing: regfile writes before read.
    function automatic logic [SEL_W-1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                                 input shadow_t ex, input shadow_t mem);
        if (reg_match(src, ex) && !ex.is_load) return FWD_MEM;
        if (reg_match(src, mem))               return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline entry register.
//   i_clk    : core clock
//   i_rst    : synchronous active-high reset (entry becomes invalid)
//   i_hold   : keep current contents (global freeze)
//   i_bubble : load an invalid entry instead of i_d
//   i_d      : next entry contents
//   o_q      : current entry
module hazard_shadow_stage
    import hazard_fwd_ctrl_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_hold,
    input  logic    i_bubble,
    input  shadow_t i_d,
    output shadow_t o_q
);

    shadow_t r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_q <= '0;
        else if (!i_hold)
            r_q <= i_bubble ? '0 : i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// EX-stage operand forwarding and stall/flush controller for a 5-stage core.
// Keeps a shadow of EX/MEM/WB destinations, registers the forwarding selects
// for the instruction entering EX, and raises load-use stall / branch flush.
// Widths come from hazard_fwd_ctrl_pkg.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_freeze            : global stall, holds all state; comb outputs forced 0
//   i_id_*              : decoded ID-stage instruction fields
//   i_ex_branch_taken   : EX resolved a taken branch/jump
//   o_fwd_a_sel/_b_sel  : registered EX operand mux selects
//   o_stall_pc/_ifid    : hold PC and IF/ID (comb)
//   o_flush_ifid        : clear IF/ID (comb)
//   o_bubble_idex       : insert NOP into ID/EX (comb)
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_freeze,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_mem_read,
    input  logic                  i_ex_branch_taken,
    output logic [SEL_W-1:0]      o_fwd_a_sel,
    output logic [SEL_W-1:0]      o_fwd_b_sel,
    output logic                  o_stall_pc,
    output logic                  o_stall_ifid,
    output logic                  o_flush_ifid,
    output logic                  o_bubble_idex
);

    localparam int STAGES = 3;  // 0 = EX, 1 = MEM, 2 = WB

    shadow_t w_d   [STAGES];
    shadow_t w_q   [STAGES];
    logic    w_bub [STAGES];

    state_e           r_state;
    logic [SEL_W-1:0] r_fwd_a;
    logic [SEL_W-1:0] r_fwd_b;

    logic w_hazard;
    logic w_enter;

    // The stall cycle always leaves a bubble in EX, so a second back-to-back
    // stall is impossible; the state guard just makes that explicit.
    assign w_hazard = i_id_valid && w_q[0].is_load && (r_state != ST_LOAD_STALL) &&
                      (reg_match(i_id_rs1, w_q[0]) || reg_match(i_id_rs2, w_q[0]));

    assign w_enter = i_id_valid && !w_hazard && !i_ex_branch_taken;

    assign w_d[0]   = '{valid: 1'b1, rd: i_id_rd, reg_write: i_id_reg_write, is_load: i_id_mem_read};
    assign w_bub[0] = !w_enter;
    assign w_d[1]   = w_q[0];
    assign w_bub[1] = 1'b0;
    assign w_d[2]   = w_q[1];
    assign w_bub[2] = 1'b0;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        hazard_shadow_stage u_stage (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_hold   (i_freeze),
            .i_bubble (w_bub[g]),
            .i_d      (w_d[g]),
            .o_q      (w_q[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_fwd_a <= FWD_REG;
            r_fwd_b <= FWD_REG;
        end else if (!i_freeze) begin
            if (i_ex_branch_taken)
                r_state <= ST_FLUSH;
            else if (w_hazard)
                r_state <= ST_LOAD_STALL;
            else
                r_state <= ST_RUN;
            // Selects are resolved against the shadow as it stands now, which is
            // exactly EX/MEM as seen by this instruction once it is in EX.
            r_fwd_a <= w_enter ? fwd_sel(i_id_rs1, w_q[0], w_q[1]) : FWD_REG;
            r_fwd_b <= w_enter ? fwd_sel(i_id_rs2, w_q[0], w_q[1]) : FWD_REG;
        end
    end

    always_comb begin
        o_stall_pc    = 1'b0;
        o_stall_ifid  = 1'b0;
        o_flush_ifid  = 1'b0;
        o_bubble_idex = 1'b0;
        if (!i_freeze) begin
            if (i_ex_branch_taken) begin
                // Flush wins: the stalled consumer is on the wrong path anyway.
                o_flush_ifid  = 1'b1;
                o_bubble_idex = 1'b1;
            end else if (w_hazard) begin
                o_stall_pc    = 1'b1;
                o_stall_ifid  = 1'b1;
                o_bubble_idex = 1'b1;
            end
        end
    end

    assign o_fwd_a_sel = r_fwd_a;
    assign o_fwd_b_sel = r_fwd_b;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       freeze = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, br = 1'b0;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_pc, stall_ifid, flush_ifid, bubble_idex;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_freeze          (freeze),
        .i_id_valid        (id_valid),
        .i_id_rs1          (id_rs1),
        .i_id_rs2          (id_rs2),
        .i_id_rd           (id_rd),
        .i_id_reg_write    (id_reg_write),
        .i_id_mem_read     (id_mem_read),
        .i_ex_branch_taken (br),
        .o_fwd_a_sel       (fwd_a),
        .o_fwd_b_sel       (fwd_b),
        .o_stall_pc        (stall_pc),
        .o_stall_ifid      (stall_ifid),
        .o_flush_ifid      (flush_ifid),
        .o_bubble_idex     (bubble_idex)
    );

    // One record per cycle: inputs driven for that cycle, and the outputs
    // expected in that cycle (selects reflect the previous cycle's ID decision).
    typedef struct {
        string      name;
        logic       rst, frz, v;
        logic [4:0] rs1, rs2, rd;
        logic       rw, ld, br;
        logic [1:0] ea, eb;
        logic       est, efl, ebu;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(input string name, input logic r, input logic f, input logic v,
                               input int rs1, input int rs2, input int rd,
                               input logic rw, input logic ld, input logic b,
                               input int ea, input int eb,
                               input logic st, input logic fl, input logic bu);
        vec_t x;
        x.name = name; x.rst = r; x.frz = f; x.v = v;
        x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.rd = 5'(rd);
        x.rw = rw; x.ld = ld; x.br = b;
        x.ea = 2'(ea); x.eb = 2'(eb);
        x.est = st; x.efl = fl; x.ebu = bu;
        return x;
    endfunction

    task automatic apply_check(input vec_t x);
        logic [7:0] act, exp;
        @(negedge clk);
        rst = x.rst; freeze = x.frz; id_valid = x.v;
        id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd;
        id_reg_write = x.rw; id_mem_read = x.ld; br = x.br;
        #2;
        act = {fwd_a, fwd_b, stall_pc, stall_ifid, flush_ifid, bubble_idex};
        exp = {x.ea, x.eb, x.est, x.est, x.efl, x.ebu};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {a,b,stpc,stif,fl,bu}=%b want %b", x.name, act, exp);
        end
    endtask

    initial begin
        //                 name          rst frz v  rs1 rs2 rd rw ld br  a  b  st fl bu
        tbl.push_back(V("reset",         1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("add_x5",        0, 0, 1,  1,  2,  5, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("add_x6_x5",     0, 0, 1,  5,  1,  6, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("ex_fwd_a",      0, 0, 0,  0,  0,  0, 0, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(V("sub_x7_x2_x6",  0, 0, 1,  2,  6,  7, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("mem_fwd_b",     0, 0, 1,  6,  7,  8, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V("wb_none_ex_b",  0, 0, 1,  8,  0,  5, 1, 1, 0, 0, 2, 0, 0, 0));
        tbl.push_back(V("load_use",      0, 0, 1,  5,  5,  6, 1, 0, 0, 2, 0, 1, 0, 1));
        tbl.push_back(V("after_stall",   0, 0, 1,  5,  5,  6, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("load_fwd_wb",   0, 0, 0,  0,  0,  0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(V("lw_x9",         0, 0, 1,  1,  0,  9, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("flush_beats_lu",0, 0, 1,  9,  0, 10, 1, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(V("post_flush",    0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("add_x0",        0, 0, 1,  1,  2,  0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("use_x0",        0, 0, 1,  0,  0, 11, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("x0_no_fwd",     0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("add_x12_a",     0, 0, 1,  1,  2, 12, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("add_x12_b",     0, 0, 1,  3,  4, 12, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("use_x12",       0, 0, 1, 12, 12, 13, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("ex_over_mem",   0, 0, 0,  0,  0,  0, 0, 0, 0, 2, 2, 0, 0, 0));
        tbl.push_back(V("store_x14",     0, 0, 1,  1,  2, 14, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("use_x14_x13",   0, 0, 1, 14, 13, 15, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("no_rw_no_wb",   0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) apply_check(tbl[i]);

        // Freeze in the middle of a load-use hazard: selects and shadow hold,
        // comb outputs stay low, and the stall appears once freeze drops.
        apply_check(V("lw_x5_fwd_x15",   0, 0, 1, 15,  0,  5, 1, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            apply_check(V("freeze_hold", 0, 1, 1,  5,  1,  6, 1, 0, 0, 1, 0, 0, 0, 0));
        apply_check(V("unfreeze_lu",     0, 0, 1,  5,  1,  6, 1, 0, 0, 1, 0, 1, 0, 1));

        // Reset while in LOAD_STALL: the load in MEM must be forgotten.
        apply_check(V("rst_in_stall",    1, 0, 1,  5,  1,  6, 1, 0, 0, 0, 0, 0, 0, 0));
        apply_check(V("post_rst",        0, 0, 1,  5,  1,  6, 1, 0, 0, 0, 0, 0, 0, 0));
        apply_check(V("post_rst_sel",    0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
